// File: rtl/router_pkg.sv
// Shared flit definitions for the traffic generator / sink pair.
// A flit is a packed union: every view starts with the same valid bit and type field.
package router_pkg;

    typedef enum logic [1:0] {
        HEAD_FLIT    = 2'd0,
        BODY_FLIT    = 2'd1,
        TAIL_FLIT    = 2'd2,
        INVALID_FLIT = 2'd3
    } FLIT_TYPE_t;

    typedef struct packed {
        logic       valid;
        FLIT_TYPE_t ftype;
        logic [7:0] xaddr;
        logic [7:0] yaddr;
    } flit_head_t;

    typedef struct packed {
        logic        valid;
        FLIT_TYPE_t  ftype;
        logic [15:0] data;
    } flit_body_t;

    typedef union packed {
        flit_head_t head;
        flit_body_t body;
    } FLIT_t;

    localparam int FLIT_SIZE = $bits(FLIT_t);

endpackage

// File: rtl/traffic_sink.sv
// Downstream endpoint of a flit link: grants one packet at a time, checks HEAD/BODY*/TAIL
// ordering, records head address and body XOR checksum, and counts good packets and errors.
module traffic_sink
    import router_pkg::*;
#(
    parameter int BODY_COUNT = 1,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_transmit,
    output logic             o_send,
    input  FLIT_t            i_flit,
    output logic             o_pkt_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_pkt_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [7:0]       o_last_xaddr,
    output logic [7:0]       o_last_yaddr,
    output logic [15:0]      o_last_csum,
    output logic             o_busy
);

    localparam int BC_W  = $clog2(BODY_COUNT + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HEAD,
        S_RECV_BODY,
        S_WAIT_TAIL,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   body_cnt_q, body_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       csum_q, csum_d;
    logic [7:0]        xtmp_q, xtmp_d, ytmp_q, ytmp_d;
    logic              pkt_done_q, pkt_done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [7:0]        last_x_q, last_x_d, last_y_q, last_y_d;
    logic [15:0]       last_csum_q, last_csum_d;

    logic       accepted;
    FLIT_TYPE_t ftype;
    logic       tmo_hit;
    logic       raise_err;

    assign accepted = i_flit.head.valid;
    assign ftype    = i_flit.head.ftype;
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));
    // Grant is combinational so the generator sees it in the same cycle it requests.
    assign o_send   = (state_q == S_IDLE) && i_enable && i_transmit && !reset;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        body_cnt_d  = body_cnt_q;
        tmo_d       = tmo_q;
        csum_d      = csum_q;
        xtmp_d      = xtmp_q;
        ytmp_d      = ytmp_q;
        pkt_done_d  = 1'b0;
        err_d       = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        last_csum_d = last_csum_q;
        raise_err   = 1'b0;

        if (state_q == S_IDLE) begin
            body_cnt_d = '0;
            csum_d     = '0;
            tmo_d      = '0;
            if (o_send) state_d = S_WAIT_HEAD;
        end else if (accepted) begin
            // An accepted flit always wins over a coincident timeout.
            tmo_d = '0;
            case (state_q)
                S_WAIT_HEAD: begin
                    if (ftype == HEAD_FLIT) begin
                        xtmp_d  = i_flit.head.xaddr;
                        ytmp_d  = i_flit.head.yaddr;
                        state_d = S_RECV_BODY;
                    end else begin
                        raise_err = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
                S_RECV_BODY: begin
                    if (ftype == BODY_FLIT) begin
                        csum_d     = csum_q ^ i_flit.body.data;
                        body_cnt_d = body_cnt_q + BC_W'(1);
                        if (body_cnt_q == BC_W'(BODY_COUNT - 1)) state_d = S_WAIT_TAIL;
                    end else begin
                        raise_err = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
                S_WAIT_TAIL: begin
                    if (ftype == TAIL_FLIT) begin
                        last_x_d    = xtmp_q;
                        last_y_d    = ytmp_q;
                        last_csum_d = csum_q;
                        pkt_done_d  = 1'b1;
                        if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        state_d = S_IDLE;
                    end else begin
                        raise_err = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
                default: begin
                    if (ftype == TAIL_FLIT) state_d = S_IDLE;
                end
            endcase
        end else if (tmo_hit) begin
            // Timeout while draining is a silent recovery, not a second error.
            raise_err = (state_q != S_DRAIN);
            state_d   = S_IDLE;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (raise_err) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            body_cnt_q  <= '0;
            tmo_q       <= '0;
            csum_q      <= '0;
            xtmp_q      <= '0;
            ytmp_q      <= '0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            last_csum_q <= '0;
        end else begin
            state_q     <= state_d;
            body_cnt_q  <= body_cnt_d;
            tmo_q       <= tmo_d;
            csum_q      <= csum_d;
            xtmp_q      <= xtmp_d;
            ytmp_q      <= ytmp_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            last_csum_q <= last_csum_d;
        end
    end

    assign o_pkt_done   = pkt_done_q;
    assign o_err        = err_q;
    assign o_pkt_count  = pkt_cnt_q;
    assign o_err_count  = err_cnt_q;
    assign o_last_xaddr = last_x_q;
    assign o_last_yaddr = last_y_q;
    assign o_last_csum  = last_csum_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: instance a (BODY_COUNT=1, CNT_W=2) and instance b (BODY_COUNT=3).
// All inputs change and all outputs are sampled 1ns after the rising edge.
module tb_traffic_sink;
    import router_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic tx_a = 1'b0, tx_b = 1'b0;
    FLIT_t flit_a, flit_b;

    logic       send_a, done_a, err_a, busy_a;
    logic [1:0] pcnt_a, ecnt_a;
    logic [7:0] lx_a, ly_a;
    logic [15:0] lc_a;

    logic        send_b, done_b, err_b, busy_b;
    logic [15:0] pcnt_b, ecnt_b;
    logic [7:0]  lx_b, ly_b;
    logic [15:0] lc_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    traffic_sink #(.BODY_COUNT(1), .CNT_W(2), .TIMEOUT(64)) dut_a (
        .clk(clk), .reset(reset), .i_enable(en), .i_transmit(tx_a), .o_send(send_a),
        .i_flit(flit_a), .o_pkt_done(done_a), .o_err(err_a), .o_pkt_count(pcnt_a),
        .o_err_count(ecnt_a), .o_last_xaddr(lx_a), .o_last_yaddr(ly_a),
        .o_last_csum(lc_a), .o_busy(busy_a)
    );

    traffic_sink #(.BODY_COUNT(3), .CNT_W(16), .TIMEOUT(64)) dut_b (
        .clk(clk), .reset(reset), .i_enable(en), .i_transmit(tx_b), .o_send(send_b),
        .i_flit(flit_b), .o_pkt_done(done_b), .o_err(err_b), .o_pkt_count(pcnt_b),
        .o_err_count(ecnt_b), .o_last_xaddr(lx_b), .o_last_yaddr(ly_b),
        .o_last_csum(lc_b), .o_busy(busy_b)
    );

    function automatic FLIT_t mk_head(input logic [7:0] x, input logic [7:0] y);
        FLIT_t f;
        f.head.valid = 1'b1;
        f.head.ftype = HEAD_FLIT;
        f.head.xaddr = x;
        f.head.yaddr = y;
        return f;
    endfunction

    function automatic FLIT_t mk_body(input logic [15:0] d);
        FLIT_t f;
        f.body.valid = 1'b1;
        f.body.ftype = BODY_FLIT;
        f.body.data  = d;
        return f;
    endfunction

    function automatic FLIT_t mk_tail();
        FLIT_t f;
        f.body.valid = 1'b1;
        f.body.ftype = TAIL_FLIT;
        f.body.data  = 16'h0;
        return f;
    endfunction

    function automatic FLIT_t mk_idle();
        FLIT_t f;
        f.body.valid = 1'b0;
        f.body.ftype = TAIL_FLIT;
        f.body.data  = 16'hDEAD;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant then back-to-back HEAD/BODY/TAIL on instance a; returns in the cycle o_pkt_done is visible.
    task automatic pkt_a(input logic [7:0] x, input logic [7:0] y, input logic [15:0] d);
        tx_a = 1'b1;
        tick();
        tx_a = 1'b0;
        flit_a = mk_head(x, y);
        tick();
        flit_a = mk_body(d);
        tick();
        flit_a = mk_tail();
        tick();
        flit_a = mk_idle();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_a = mk_idle();
        flit_b = mk_idle();
        tick();
        tick();

        // Reset values, with a request held during reset
        tx_a = 1'b1;
        en   = 1'b1;
        #1;
        check("send_in_reset", {31'b0, send_a}, 32'h0);
        tx_a = 1'b0;
        check("rst_pcnt", {30'b0, pcnt_a}, 32'h0);
        check("rst_ecnt", {30'b0, ecnt_a}, 32'h0);
        check("rst_last", {8'b0, lx_a, lc_a}, 32'h0);
        check("rst_busy_done_err", {29'b0, busy_a, done_a, err_a}, 32'h0);
        reset = 1'b0;
        tick();

        // Grant gated by enable, then same-cycle grant on raising it
        en   = 1'b0;
        tx_a = 1'b1;
        #1;
        check("send_gated", {31'b0, send_a}, 32'h0);
        tick();
        check("busy_gated", {31'b0, busy_a}, 32'h0);
        en = 1'b1;
        #1;
        check("send_enabled", {31'b0, send_a}, 32'h1);
        tx_a = 1'b0;
        #1;

        // Good packet, BODY_COUNT=1: done visible BODY_COUNT+3 = 4 cycles after grant cycle
        pkt_a(8'h12, 8'h34, 16'h00AB);
        check("p1_done", {31'b0, done_a}, 32'h1);
        check("p1_pcnt", {30'b0, pcnt_a}, 32'h1);
        check("p1_xaddr", {24'b0, lx_a}, 32'h12);
        check("p1_yaddr", {24'b0, ly_a}, 32'h34);
        check("p1_csum", {16'b0, lc_a}, 32'h00AB);
        check("p1_ecnt", {30'b0, ecnt_a}, 32'h0);
        check("p1_busy", {31'b0, busy_a}, 32'h0);
        tick();
        check("p1_done_pulse", {31'b0, done_a}, 32'h0);
        check("p1_pcnt_hold", {30'b0, pcnt_a}, 32'h1);

        // HEAD then TAIL: error, drain, last_* untouched
        tx_a = 1'b1;
        tick();
        tx_a = 1'b0;
        flit_a = mk_head(8'hEE, 8'hFF);
        tick();
        flit_a = mk_tail();
        tick();
        flit_a = mk_idle();
        check("mb_err", {31'b0, err_a}, 32'h1);
        check("mb_ecnt", {30'b0, ecnt_a}, 32'h1);
        check("mb_drain_busy", {31'b0, busy_a}, 32'h1);
        check("mb_no_done", {31'b0, done_a}, 32'h0);
        tick();
        check("mb_err_pulse", {31'b0, err_a}, 32'h0);
        flit_a = mk_body(16'h5555);
        tick();
        flit_a = mk_tail();
        tick();
        flit_a = mk_idle();
        check("mb_drain_idle", {31'b0, busy_a}, 32'h0);
        check("mb_drain_no_err", {30'b0, ecnt_a}, 32'h1);
        check("mb_last_kept", {lx_a, ly_a, lc_a}, 32'h123400AB);
        pkt_a(8'h56, 8'h78, 16'h1111);
        check("p2_done", {31'b0, done_a}, 32'h1);
        check("p2_pcnt", {30'b0, pcnt_a}, 32'h2);
        check("p2_last", {lx_a, ly_a, lc_a}, 32'h56781111);

        // Timeout after HEAD: error on the edge sampling the 64th idle cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tx_a = 1'b1;
        tick();
        tx_a = 1'b0;
        flit_a = mk_head(8'h01, 8'h02);
        tick();
        flit_a = mk_idle();
        for (int i = 0; i < 63; i++) tick();
        check("to_63_no_err", {30'b0, busy_a, err_a}, 32'h2);
        tick();
        check("to_64_err", {31'b0, err_a}, 32'h1);
        check("to_idle", {31'b0, busy_a}, 32'h0);
        check("to_ecnt", {30'b0, ecnt_a}, 32'h1);
        check("to_last_kept", {lx_a, ly_a, lc_a}, 32'h0);
        pkt_a(8'hA0, 8'hB0, 16'hC0C0);
        check("to_next_pcnt", {30'b0, pcnt_a}, 32'h1);

        // Saturation: CNT_W=2, five good packets stop at 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt_a(8'(i), 8'(i + 1), 16'(i * 3));
            tick();
        end
        check("sat_pcnt", {30'b0, pcnt_a}, 32'h3);
        check("sat_last", {lx_a, ly_a, lc_a}, 32'h0405000C);

        // Reset mid-body drops the packet and clears everything
        tx_a = 1'b1;
        tick();
        tx_a = 1'b0;
        flit_a = mk_head(8'h99, 8'h88);
        tick();
        flit_a = mk_idle();
        tx_a = 1'b1;
        reset = 1'b1;
        tick();
        check("mr_send", {31'b0, send_a}, 32'h0);
        check("mr_counts", {28'b0, pcnt_a, ecnt_a}, 32'h0);
        check("mr_last", {lx_a, ly_a, lc_a}, 32'h0);
        check("mr_flags", {29'b0, busy_a, done_a, err_a}, 32'h0);
        tx_a = 1'b0;
        reset = 1'b0;
        tick();

        // BODY_COUNT=3 with valid=0 gaps; csum 0F0F^00FF^1234 = 1DC4
        tx_b = 1'b1;
        tick();
        tx_b = 1'b0;
        flit_b = mk_head(8'h21, 8'h43);
        tick();
        flit_b = mk_idle();
        tick();
        flit_b = mk_body(16'h0F0F);
        tick();
        flit_b = mk_idle();
        tick();
        tick();
        flit_b = mk_body(16'h00FF);
        tick();
        flit_b = mk_idle();
        tick();
        flit_b = mk_body(16'h1234);
        tick();
        flit_b = mk_idle();
        tick();
        check("b_no_early_done", {30'b0, done_b, busy_b}, 32'h1);
        flit_b = mk_tail();
        tick();
        flit_b = mk_idle();
        check("b_done", {31'b0, done_b}, 32'h1);
        check("b_csum", {16'b0, lc_b}, 32'h1DC4);
        check("b_addr", {16'b0, lx_b, ly_b}, 32'h2143);
        check("b_counts", {pcnt_b, ecnt_b}, 32'h00010000);
        tick();
        check("b_done_pulse", {31'b0, done_b}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_sink.md
# traffic_sink

Packet consumer at the downstream end of a flit link, paired with the traffic generator. Grants a pending transmit request, accepts one packet (HEAD, BODY_COUNT BODY flits, TAIL) from the generator's FIFO output, and checks flit ordering. It also records the head address and an XOR checksum of the body data, and keeps saturating packet and error counters. It is used in NoC bring-up and traffic testbenches as the endpoint that proves packets arrive intact.

## Interface
Parameters:
- BODY_COUNT, 1, BODY flits expected per packet (≥1)
- CNT_W, 16, width of packet/error counters
- TIMEOUT, 64, idle cycles tolerated mid-packet before abort (≥2)

Ports (FLIT_t, FLIT_TYPE_t, FLIT_SIZE from router_pkg):
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_enable  in  1  permits granting new packets
- i_transmit  in  1  generator request (generator's o_transmit)
- o_send  out  1  grant to generator (drives generator's i_send)
- i_flit  in  FLIT_SIZE  incoming flit (generator's o_flit); qualified only by valid bit
- o_pkt_done  out  1  one-cycle pulse: good packet completed
- o_err  out  1  one-cycle pulse: protocol error or timeout
- o_pkt_count  out  CNT_W  good packets, saturating
- o_err_count  out  CNT_W  errors, saturating
- o_last_xaddr  out  8  xaddr of last good packet
- o_last_yaddr  out  8  yaddr of last good packet
- o_last_csum  out  16  XOR of body.data of last good packet
- o_busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WAIT_HEAD, RECV_BODY, WAIT_TAIL, DRAIN.
- IDLE: o_send = i_enable & i_transmit (combinational). When o_send=1, go to WAIT_HEAD. Clear the body counter, running checksum and timeout counter.
- A flit is "accepted" on an edge where i_flit.head.valid=1. Flits with valid=0 are ignored in every state.
- WAIT_HEAD:
  - Accepted HEAD_FLIT: latch xaddr/yaddr into temporaries and go to RECV_BODY.
  - Any other accepted type: error, go to DRAIN.
- RECV_BODY:
  - Accepted BODY_FLIT: XOR body.data into the running checksum and increment the body counter. When the counter reaches BODY_COUNT, go to WAIT_TAIL.
  - Any other accepted type: error, go to DRAIN.
- WAIT_TAIL:
  - Accepted TAIL_FLIT: good packet. Commit the temporaries to o_last_*, increment o_pkt_count, pulse o_pkt_done, go to IDLE.
  - Any other accepted type: error, go to DRAIN.
- DRAIN: discard accepted flits. An accepted TAIL_FLIT or a timeout returns to IDLE. No further error is counted in DRAIN.
- Timeout: in WAIT_HEAD, RECV_BODY and WAIT_TAIL, a counter increments on every cycle with no accepted flit and clears on an accepted flit. When it reaches TIMEOUT: error, go to IDLE. In DRAIN, the timeout returns to IDLE silently.
- Error action: pulse o_err and increment o_err_count.
- Counters saturate at 2^CNT_W−1 and never wrap.
- o_last_* change only on good packets. An aborted packet never corrupts them.
- i_enable deasserting mid-packet does not abort reception; it only blocks the next grant.
- Reset asserted mid-packet: the state returns to IDLE and the partial packet is dropped without an error count.

## Timing
- Reset values: o_send=0 (IDLE, and held 0 while reset asserted), o_pkt_done=0, o_err=0, o_pkt_count=0, o_err_count=0, o_last_xaddr=0, o_last_yaddr=0, o_last_csum=0, o_busy=0.
- o_send is high in the same cycle as i_transmit. The generator samples it at that edge, and the sink is in WAIT_HEAD from the next cycle.
- o_pkt_done, o_err, the counters and o_last_* update on the edge that samples the TAIL or the offending flit, so they are visible in the following cycle. Pulses last exactly one cycle.
- Minimum packet: 1 grant cycle plus BODY_COUNT+2 accepted flits. With back-to-back valid flits, o_pkt_done appears BODY_COUNT+3 cycles after the grant cycle.
- A new grant is possible in the cycle after o_pkt_done.
- If the timeout and an accepted flit coincide, the accepted flit wins.

## Test plan
- BODY_COUNT=1: grant, then flits HEAD(x=0x12,y=0x34), BODY(0x00AB), TAIL -> o_pkt_done pulse once; o_pkt_count=1; o_last_xaddr=0x12, o_last_yaddr=0x34, o_last_csum=0x00AB; o_err_count=0.
- BODY_COUNT=3: bodies 0x0F0F, 0x00FF, 0x1234 with valid=0 gaps between flits -> o_last_csum=0x1DC4; o_pkt_done one cycle after TAIL is sampled.
- HEAD then TAIL (missing body) -> o_err pulse, o_err_count=1; sink drains and returns to IDLE; o_last_* unchanged; the next good packet is counted normally.
- HEAD then no valid flits for TIMEOUT=64 cycles -> o_err on the 64th idle cycle, state IDLE; a following good packet gives o_pkt_count=1.
- i_transmit=1 with i_enable=0 -> o_send stays 0; raise i_enable -> o_send=1 in the same cycle.
- CNT_W=2, 5 good packets -> o_pkt_count=3 (saturated). Reset asserted mid-body -> all outputs return to reset values next cycle.
